// File: rtl/rv_pkg.sv
// Shared RV32I encoding constants, ImmSrc codes and loader FSM states.
// Shared by the immediate extender, the packer and the program loader.
package rv_pkg;

    typedef enum logic [1:0] {
        IMM_I = 2'b00,
        IMM_S = 2'b01,
        IMM_B = 2'b10,
        IMM_X = 2'b11
    } imm_src_e;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_LOAD  = 2'b01,
        ST_WRITE = 2'b10,
        ST_DONE  = 2'b11
    } ld_state_e;

    // True when every bit from position lsb upward is a copy of the sign bit,
    // i.e. the value survives truncation to an (lsb+1)-bit signed field.
    function automatic logic fits_signed(input logic [31:0] v, input int unsigned lsb);
        logic signed [31:0] w_shr;
        w_shr = $signed(v) >>> lsb;
        return (w_shr == '0) || (w_shr == '1);
    endfunction

endpackage

// File: rtl/imm_packer.sv
// Combinational packer: decoded fields + immediate -> RV32I I/S/B word and
// a legality flag covering the format code and the immediate range.
module imm_packer
    import rv_pkg::*;
(
    input  logic [1:0]  i_fmt,
    input  logic [6:0]  i_opcode,
    input  logic [2:0]  i_funct3,
    input  logic [4:0]  i_rd,
    input  logic [4:0]  i_rs1,
    input  logic [4:0]  i_rs2,
    input  logic [31:0] i_imm,
    output logic [31:0] o_word,
    output logic        o_legal
);

    always_comb begin
        o_word  = '0;
        o_legal = 1'b0;
        case (imm_src_e'(i_fmt))
            IMM_I: begin
                o_word  = {i_imm[11:0], i_rs1, i_funct3, i_rd, i_opcode};
                o_legal = fits_signed(i_imm, 11);
            end
            IMM_S: begin
                o_word  = {i_imm[11:5], i_rs2, i_rs1, i_funct3, i_imm[4:0], i_opcode};
                o_legal = fits_signed(i_imm, 11);
            end
            // Branch offsets are always even, so imm[0] has no slot in the word.
            IMM_B: begin
                o_word  = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_funct3,
                           i_imm[4:1], i_imm[11], i_opcode};
                o_legal = fits_signed(i_imm, 12) && !i_imm[0];
            end
            default: begin
                o_word  = '0;
                o_legal = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/imm_pack_loader.sv
// Program loader: accepts decoded instruction bundles, range-checks and packs
// them, and writes one word per two cycles into instruction memory.
module imm_pack_loader
    import rv_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned DEPTH_WORDS = 64
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [1:0]                   in_fmt,
    input  logic [6:0]                   in_opcode,
    input  logic [2:0]                   in_funct3,
    input  logic [4:0]                   in_rd,
    input  logic [4:0]                   in_rs1,
    input  logic [4:0]                   in_rs2,
    input  logic [31:0]                  in_imm,
    input  logic                         in_last,
    output logic                         im_we,
    output logic [31:0]                  im_addr,
    output logic [31:0]                  im_wdata,
    output logic                         busy,
    output logic                         done,
    output logic                         err,
    output logic                         full,
    output logic [$clog2(DEPTH_WORDS):0] word_count
);

    localparam int unsigned          CNT_W     = $clog2(DEPTH_WORDS) + 1;
    localparam logic [CNT_W-1:0]     DEPTH_CNT = CNT_W'(DEPTH_WORDS);

    ld_state_e          r_state;
    ld_state_e          w_next;
    logic [31:0]        r_wdata;
    logic               r_last;
    logic [31:0]        r_addr;
    logic [CNT_W-1:0]   r_count;
    logic [CNT_W-1:0]   w_count_inc;
    logic               r_err;
    logic               r_full;
    logic [31:0]        w_word;
    logic               w_legal;
    logic               w_accept;
    logic               w_at_depth;

    imm_packer u_packer (
        .i_fmt    (in_fmt),
        .i_opcode (in_opcode),
        .i_funct3 (in_funct3),
        .i_rd     (in_rd),
        .i_rs1    (in_rs1),
        .i_rs2    (in_rs2),
        .i_imm    (in_imm),
        .o_word   (w_word),
        .o_legal  (w_legal)
    );

    assign w_accept    = (r_state == ST_LOAD) && in_valid;
    assign w_count_inc = r_count + CNT_W'(1);
    assign w_at_depth  = (w_count_inc == DEPTH_CNT);

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: if (start) w_next = ST_LOAD;
            ST_LOAD:          if (in_valid) w_next = w_legal ? ST_WRITE : ST_DONE;
            ST_WRITE:         w_next = (r_last || w_at_depth) ? ST_DONE : ST_LOAD;
            default:          w_next = ST_IDLE;
        endcase
    end

    // Handshake outputs decode straight from state so an async reset drops im_we at once.
    assign in_ready   = (r_state == ST_LOAD);
    assign im_we      = (r_state == ST_WRITE);
    assign busy       = (r_state == ST_LOAD) || (r_state == ST_WRITE);
    assign done       = (r_state == ST_DONE);
    assign err        = r_err;
    assign full       = r_full;
    assign im_addr    = r_addr;
    assign im_wdata   = r_wdata;
    assign word_count = r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_addr  <= BASE_ADDR;
            r_count <= '0;
            r_err   <= 1'b0;
            r_full  <= 1'b0;
            r_wdata <= '0;
            r_last  <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_addr  <= BASE_ADDR;
                        r_count <= '0;
                        r_err   <= 1'b0;
                        r_full  <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (w_accept) begin
                        if (w_legal) begin
                            r_wdata <= w_word;
                            r_last  <= in_last;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                ST_WRITE: begin
                    r_addr  <= r_addr + 32'd4;
                    r_count <= w_count_inc;
                    if (w_at_depth && !r_last) r_full <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_imm_pack_loader.sv
// Randomized self-checking bench for imm_pack_loader with an arithmetic
// reference model of the packing/range rules and of the load sequence.
module tb_imm_pack_loader;
    import rv_pkg::*;

    localparam logic [31:0] BASE  = 32'h0000_0000;
    localparam int          DEPTH = 4;

    typedef struct {
        logic [1:0]  fmt;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic        last;
    } bundle_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  in_fmt = '0;
    logic [6:0]  in_opcode = '0;
    logic [2:0]  in_funct3 = '0;
    logic [4:0]  in_rd = '0;
    logic [4:0]  in_rs1 = '0;
    logic [4:0]  in_rs2 = '0;
    logic [31:0] in_imm = '0;
    logic        in_last = 1'b0;
    logic        im_we;
    logic [31:0] im_addr;
    logic [31:0] im_wdata;
    logic        busy;
    logic        done;
    logic        err;
    logic        full;
    logic [2:0]  word_count;

    int n_checks = 0;
    int n_errors = 0;

    int m_count;
    bit m_stopped;
    bit m_err;
    bit m_full;

    imm_pack_loader #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_fmt     (in_fmt),
        .in_opcode  (in_opcode),
        .in_funct3  (in_funct3),
        .in_rd      (in_rd),
        .in_rs1     (in_rs1),
        .in_rs2     (in_rs2),
        .in_imm     (in_imm),
        .in_last    (in_last),
        .im_we      (im_we),
        .im_addr    (im_addr),
        .im_wdata   (im_wdata),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .full       (full),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: encode from the instruction-set field layout with plain arithmetic.
    function automatic void model(input bundle_t b, output bit legal, output logic [31:0] w);
        int v;
        logic [31:0] regs;
        v = $signed(b.imm);
        regs = (32'(b.rs1) << 15) | (32'(b.f3) << 12) | 32'(b.op);
        case (b.fmt)
            2'b00: begin
                legal = (v >= -2048) && (v <= 2047);
                w = ((b.imm & 32'hFFF) << 20) | regs | (32'(b.rd) << 7);
            end
            2'b01: begin
                legal = (v >= -2048) && (v <= 2047);
                w = (((b.imm >> 5) & 32'h7F) << 25) | (32'(b.rs2) << 20) | regs
                    | ((b.imm & 32'h1F) << 7);
            end
            2'b10: begin
                legal = (v >= -4096) && (v <= 4094) && (v % 2 == 0);
                w = (((b.imm >> 12) & 32'h1) << 31) | (((b.imm >> 5) & 32'h3F) << 25)
                    | (32'(b.rs2) << 20) | regs | (((b.imm >> 1) & 32'hF) << 8)
                    | (((b.imm >> 11) & 32'h1) << 7);
            end
            default: begin
                legal = 1'b0;
                w = '0;
            end
        endcase
    endfunction

    task automatic drive_bundle(input bundle_t b, input int gap, output bit acc);
        repeat (gap) @(negedge clk);
        @(negedge clk);
        in_fmt = b.fmt; in_opcode = b.op; in_funct3 = b.f3; in_rd = b.rd;
        in_rs1 = b.rs1; in_rs2 = b.rs2; in_imm = b.imm; in_last = b.last;
        in_valid = 1'b1;
        acc = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (in_ready) begin
                acc = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (acc) @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic process(input bundle_t b, input int gap);
        bit legal;
        bit acc;
        logic [31:0] w;
        model(b, legal, w);
        drive_bundle(b, gap, acc);
        chk("accepted", 32'(acc), 32'(!m_stopped));
        if (!acc) begin
            chk("no_we_when_refused", 32'(im_we), 32'd0);
        end else if (legal) begin
            chk("we", 32'(im_we), 32'd1);
            chk("addr", im_addr, BASE + 32'(4 * m_count));
            chk("wdata", im_wdata, w);
            m_count++;
            if (b.last || m_count == DEPTH) m_stopped = 1'b1;
            if (!b.last && m_count == DEPTH) m_full = 1'b1;
        end else begin
            chk("we_illegal", 32'(im_we), 32'd0);
            m_stopped = 1'b1;
            m_err = 1'b1;
        end
    endtask

    task automatic do_start(input bit with_valid);
        @(negedge clk);
        in_fmt = 2'b00; in_opcode = OP_IMM; in_imm = 32'd1;
        start = 1'b1;
        in_valid = with_valid;
        @(negedge clk);
        start = 1'b0;
        in_valid = 1'b0;
        m_count = 0; m_stopped = 1'b0; m_err = 1'b0; m_full = 1'b0;
        chk("start_ready", 32'(in_ready), 32'd1);
        chk("start_busy", 32'(busy), 32'd1);
        chk("start_done", 32'(done), 32'd0);
        chk("start_err", 32'(err), 32'd0);
        chk("start_full", 32'(full), 32'd0);
        chk("start_count", 32'(word_count), 32'd0);
        chk("start_addr", im_addr, BASE);
    endtask

    task automatic end_check(input string tag);
        @(negedge clk);
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_we"}, 32'(im_we), 32'd0);
        chk({tag, "_err"}, 32'(err), 32'(m_err));
        chk({tag, "_full"}, 32'(full), 32'(m_full));
        chk({tag, "_count"}, 32'(word_count), 32'(m_count));
        chk({tag, "_addr"}, im_addr, BASE + 32'(4 * m_count));
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_we"}, 32'(im_we), 32'd0);
        chk({tag, "_ready"}, 32'(in_ready), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_err"}, 32'(err), 32'd0);
        chk({tag, "_full"}, 32'(full), 32'd0);
        chk({tag, "_count"}, 32'(word_count), 32'd0);
        chk({tag, "_addr"}, im_addr, BASE);
        chk({tag, "_wdata"}, im_wdata, 32'd0);
    endtask

    function automatic logic [31:0] rand_imm();
        int tbl[13] = '{-2048, 2047, 2048, -2049, -4096, 4094, 4095, 4096, -4098, 0, -1, 1, -2};
        int r;
        r = int'($urandom_range(0, 9));
        if (r < 3) return 32'(tbl[$urandom_range(0, 12)]);
        if (r < 9) return 32'(int'($urandom_range(0, 8191)) - 4096);
        return $urandom;
    endfunction

    function automatic bundle_t rand_bundle(input bit last);
        bundle_t b;
        b.fmt  = ($urandom_range(0, 19) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
        b.op   = 7'($urandom);
        b.f3   = 3'($urandom);
        b.rd   = 5'($urandom);
        b.rs1  = 5'($urandom);
        b.rs2  = 5'($urandom);
        b.imm  = rand_imm();
        b.last = last;
        return b;
    endfunction

    initial begin
        bundle_t b;
        int len;

        m_count = 0; m_stopped = 1'b1; m_err = 1'b0; m_full = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_state("rst");
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_ready", 32'(in_ready), 32'd0);

        // Directed program: I, S, B with a start pulse ignored mid-load.
        do_start(1'b0);
        b = '{2'b00, 7'b0010011, 3'b000, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0};
        process(b, 0);
        chk("ex1_word", im_wdata, 32'h0050_0093);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk("start_ignored_count", 32'(word_count), 32'd1);
        chk("start_ignored_addr", im_addr, BASE + 32'd4);
        b = '{2'b01, 7'b0100011, 3'b010, 5'd0, 5'd0, 5'd2, 32'd8, 1'b0};
        process(b, 0);
        chk("ex2_word", im_wdata, 32'h0020_2423);
        b = '{2'b10, 7'b1100011, 3'b000, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC, 1'b1};
        process(b, 0);
        chk("ex3_word", im_wdata, 32'hFE20_8EE3);
        end_check("ex3");

        // Range violations, with start and in_valid together in DONE.
        do_start(1'b1);
        b = '{2'b00, 7'b0010011, 3'b000, 5'd1, 5'd0, 5'd0, 32'd2048, 1'b0};
        process(b, 0);
        end_check("ex4a");
        do_start(1'b0);
        b = '{2'b10, 7'b1100011, 3'b000, 5'd0, 5'd1, 5'd2, 32'd5, 1'b1};
        process(b, 1);
        end_check("ex4b");

        // Memory fills before in_last arrives; the fifth bundle is refused.
        do_start(1'b0);
        for (int i = 0; i < 5; i++) begin
            b = '{2'b00, 7'b0010011, 3'b000, 5'(i), 5'd0, 5'd0, 32'(i), 1'b0};
            process(b, 0);
        end
        end_check("ex5");

        for (int p = 0; p < 40; p++) begin
            do_start($urandom_range(0, 1) == 1);
            len = int'($urandom_range(1, 6));
            for (int i = 0; i < len; i++) begin
                b = rand_bundle(i == len - 1);
                process(b, int'($urandom_range(0, 2)));
            end
            end_check("rand");
        end

        // Reset in the middle of a write.
        do_start(1'b0);
        b = '{2'b00, 7'b0010011, 3'b000, 5'd3, 5'd4, 5'd0, 32'd100, 1'b0};
        process(b, 0);
        rst_n = 1'b0;
        #1;
        check_reset_state("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_rst_ready", 32'(in_ready), 32'd0);
            chk("post_rst_we", 32'(im_we), 32'd0);
        end
        in_valid = 1'b0;
        do_start(1'b0);
        b = '{2'b00, 7'b0010011, 3'b000, 5'd1, 5'd0, 5'd0, 32'd5, 1'b1};
        process(b, 0);
        end_check("post_rst");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
